dequeue_agent_v0_1: RTL

Dequeue-side control agent of the PIFO scheduler, the counterpart of the enqueue agent. It picks one non-empty output-port PIFO at a time and pops its head entry. It then streams that port's packet chunks out of the port buffer toward the egress interface, one chunk per handshake, until tlast. It keeps per-port dequeued-packet and chunk counters, readable over the same CPU request/response channel the enqueue agent uses.

---
 rtl/dequeue_agent_v0_1.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dequeue_agent_v0_1.sv
// Dequeue agent: pops one non-empty port PIFO at a time, streams that port's chunks to egress until tlast,
// and keeps per-port packet/chunk counters readable over the CPU channel. Define DQ_STRICT_PRIORITY_EN for strict priority.

module dq_port_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_chunk_inc,
  input  logic        i_pkt_inc,
  output logic [31:0] o_pkt_cnt,
  output logic [31:0] o_chunk_cnt
);
  logic [31:0] r_pkt;
  logic [31:0] r_chunk;

  // Free-running 32-bit counters; natural wrap at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt   <= '0;
      r_chunk <= '0;
    end else begin
      if (i_chunk_inc) r_chunk <= r_chunk + 32'd1;
      if (i_pkt_inc)   r_pkt   <= r_pkt + 32'd1;
    end
  end

  assign o_pkt_cnt   = r_pkt;
  assign o_chunk_cnt = r_chunk;
endmodule

module dequeue_agent_v0_1 #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = 3
) (
  input  logic                 axis_aclk,
  input  logic                 axis_reset,
  input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
  output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_tvalid,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_tlast,
  output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
  output logic [SEL_W-1:0]     m_axis_port_sel,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  input  logic [7:0]           s_axi_addr,
  input  logic                 s_axi_req_valid,
  output logic [31:0]          m_axi_data,
  output logic                 m_axi_resp_valid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [1:0]           r_state;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     w_win;
  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_any;
  logic                 w_tvalid;
  logic                 w_last;
  logic                 w_hs;
  logic [NUM_PORTS-1:0] w_port_hit;

  logic [NUM_PORTS-1:0][31:0] w_pkt_cnt;
  logic [NUM_PORTS-1:0][31:0] w_chunk_cnt;
  logic [31:0]                w_rd_val;
  logic                       r_resp_valid;
  logic [31:0]                r_data;

  assign w_elig = ~s_axis_pifo_empty;
  assign w_any  = |w_elig;

`ifdef DQ_STRICT_PRIORITY_EN
  // Highest eligible index wins; the CPU port sits at the top.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_elig[i]) w_win = SEL_W'(i);
  end
`else
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_win_hi;
  logic [SEL_W-1:0] w_win_lo;
  logic             w_fnd_hi;

  // Search rr_ptr+1..top first, then wrap to 0..rr_ptr; lowest index in each half wins.
  always_comb begin
    w_win_hi = '0;
    w_win_lo = '0;
    w_fnd_hi = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        if (SEL_W'(i) > r_rr_ptr) begin
          w_win_hi = SEL_W'(i);
          w_fnd_hi = 1'b1;
        end else begin
          w_win_lo = SEL_W'(i);
        end
      end
    end
    w_win = w_fnd_hi ? w_win_hi : w_win_lo;
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset)
      r_rr_ptr <= SEL_W'(NUM_PORTS - 1);
    else if (r_state == S_XFER && w_hs && w_last)
      r_rr_ptr <= r_sel;
  end
`endif

  // sel is only loaded in IDLE, so egress never sees it move while a chunk is pending.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_sel   <= w_win;
          r_state <= S_POP;
        end
        S_POP:  r_state <= S_XFER;
        S_XFER: if (w_hs && w_last) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_tvalid = (r_state == S_XFER) & s_axis_buffer_tvalid[r_sel];
  assign w_last   = w_tvalid & s_axis_buffer_tlast[r_sel];
  assign w_hs     = w_tvalid & m_axis_tready;

  assign m_axis_tvalid   = w_tvalid;
  assign m_axis_tlast    = w_last;
  assign m_axis_port_sel = r_sel;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_port_hit[g]              = (r_sel == SEL_W'(g));
    assign m_axis_ctl_pifo_out_en[g]  = (r_state == S_POP) & w_port_hit[g];
    assign m_axis_ctl_buffer_rd_en[g] = w_hs & w_port_hit[g];

    dq_port_cnt u_cnt (
      .clk         (axis_aclk),
      .rst         (axis_reset),
      .i_chunk_inc (w_hs & w_port_hit[g]),
      .i_pkt_inc   (w_hs & w_last & w_port_hit[g]),
      .o_pkt_cnt   (w_pkt_cnt[g]),
      .o_chunk_cnt (w_chunk_cnt[g])
    );
  end

  // Unmapped port or select reads as zero but still gets a response.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (s_axi_addr[3:0] == 4'(i)) begin
        if (s_axi_addr[7:4] == 4'd0)      w_rd_val = w_pkt_cnt[i];
        else if (s_axi_addr[7:4] == 4'd1) w_rd_val = w_chunk_cnt[i];
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_resp_valid <= 1'b0;
      r_data       <= '0;
    end else begin
      r_resp_valid <= s_axi_req_valid;
      if (s_axi_req_valid) r_data <= w_rd_val;
    end
  end

  assign m_axi_resp_valid = r_resp_valid;
  assign m_axi_data       = r_data;
endmodule
